// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: state encodings,
// the default memory timeout and the pipeline nop constants.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        CTRL_RUN  = 2'd0,
        CTRL_WAIT = 2'd1,
        CTRL_HALT = 2'd2
    } ctrl_state_e;

    localparam int MEM_TIMEOUT_DEF = 64;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use comparator between the decode sources and the
// destination register of a load in execute.
module pipe_hazard_ctrl_hazard_detect #(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] rs1,
    input  logic [REG_W-1:0] rs2,
    input  logic             use_rs1,
    input  logic             use_rs2,
    input  logic [REG_W-1:0] rd,
    input  logic             is_load,
    output logic             load_use
);

    // x0 is never a real dependency
    assign load_use = is_load && (rd != '0) &&
                      ((use_rs1 && (rs1 == rd)) || (use_rs2 && (rs2 == rd)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/bubble controller for the 5-stage core with a RUN/WAIT/HALT FSM.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int REG_W       = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] dec_i_rs1,
    input  logic [REG_W-1:0] dec_i_rs2,
    input  logic             dec_i_use_rs1,
    input  logic             dec_i_use_rs2,
    input  logic [REG_W-1:0] exe_i_rd,
    input  logic             exe_i_is_load,
    input  logic             exe_i_mispredict,
    input  logic             mem_i_req,
    input  logic             mem_i_ready,
    input  logic             wb_i_ebreak,
    output logic             ctrl_o_regF_stall,
    output logic             ctrl_o_regD_stall,
    output logic             ctrl_o_regD_bubble,
    output logic             ctrl_o_regE_stall,
    output logic             ctrl_o_regE_bubble,
    output logic             ctrl_o_regM_stall,
    output logic             ctrl_o_regW_bubble,
    output logic             ctrl_o_halt,
    output logic             ctrl_o_timeout,
    output logic [31:0]      perf_o_stall_cycles,
    output logic [31:0]      perf_o_flushes,
    output logic [31:0]      perf_o_load_use
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MEM_TIMEOUT);

    ctrl_state_e      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             timeout_q, timeout_nxt;
    logic             load_use, mem_stall;
    logic             act_flush, act_load_use;

    pipe_hazard_ctrl_hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
        .rs1      (dec_i_rs1),
        .rs2      (dec_i_rs2),
        .use_rs1  (dec_i_use_rs1),
        .use_rs2  (dec_i_use_rs2),
        .rd       (exe_i_rd),
        .is_load  (exe_i_is_load),
        .load_use (load_use)
    );

    assign mem_stall = mem_i_req && !mem_i_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CTRL_RUN;
            cnt       <= '0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            timeout_q <= timeout_nxt;
        end
    end

    // A dropped request while waiting counts as completion.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        timeout_nxt = timeout_q;
        case (state)
            CTRL_RUN: begin
                if (wb_i_ebreak) begin
                    state_nxt = CTRL_HALT;
                end else if (mem_stall) begin
                    state_nxt = CTRL_WAIT;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            CTRL_WAIT: begin
                if (wb_i_ebreak) begin
                    state_nxt = CTRL_HALT;
                end else if (!mem_stall) begin
                    state_nxt = CTRL_RUN;
                    cnt_nxt   = '0;
                end else if (cnt >= CNT_LAST) begin
                    state_nxt   = CTRL_HALT;
                    timeout_nxt = 1'b1;
                end else if (cnt != CNT_MAX) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            CTRL_HALT: begin
                state_nxt = CTRL_HALT;
            end
            default: begin
                state_nxt = CTRL_RUN;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        ctrl_o_regF_stall  = 1'b0;
        ctrl_o_regD_stall  = 1'b0;
        ctrl_o_regD_bubble = 1'b0;
        ctrl_o_regE_stall  = 1'b0;
        ctrl_o_regE_bubble = 1'b0;
        ctrl_o_regM_stall  = 1'b0;
        ctrl_o_regW_bubble = 1'b0;
        act_flush          = 1'b0;
        act_load_use       = 1'b0;
        if (state == CTRL_HALT || mem_stall) begin
            ctrl_o_regF_stall  = 1'b1;
            ctrl_o_regD_stall  = 1'b1;
            ctrl_o_regE_stall  = 1'b1;
            ctrl_o_regM_stall  = 1'b1;
            ctrl_o_regW_bubble = 1'b1;
        end else if (exe_i_mispredict) begin
            ctrl_o_regD_bubble = 1'b1;
            ctrl_o_regE_bubble = 1'b1;
            act_flush          = 1'b1;
        end else if (load_use) begin
            ctrl_o_regF_stall  = 1'b1;
            ctrl_o_regD_stall  = 1'b1;
            ctrl_o_regE_bubble = 1'b1;
            act_load_use       = 1'b1;
        end
    end

    assign ctrl_o_halt    = (state == CTRL_HALT);
    assign ctrl_o_timeout = timeout_q;

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_o_stall_cycles <= '0;
            perf_o_flushes      <= '0;
            perf_o_load_use     <= '0;
        end else if (state != CTRL_HALT) begin
            if (ctrl_o_regF_stall) perf_o_stall_cycles <= perf_o_stall_cycles + 32'd1;
            if (act_flush)         perf_o_flushes      <= perf_o_flushes + 32'd1;
            if (act_load_use)      perf_o_load_use     <= perf_o_load_use + 32'd1;
        end
    end
`else
    assign perf_o_stall_cycles = '0;
    assign perf_o_flushes      = '0;
    assign perf_o_load_use     = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: stimulus queues expected control
// vectors, a negedge monitor pops and compares them.
module tb_pipe_hazard_ctrl;

    localparam int REG_W = 5;

    // {F_st, D_st, D_bub, E_st, E_bub, M_st, W_bub, halt, timeout}
    localparam logic [8:0] V_IDLE = 9'b000000000;
    localparam logic [8:0] V_LU   = 9'b110010000;
    localparam logic [8:0] V_MISP = 9'b001010000;
    localparam logic [8:0] V_MEM  = 9'b110101100;
    localparam logic [8:0] V_HALT = 9'b110101110;
    localparam logic [8:0] V_HTO  = 9'b110101111;

    typedef struct {
        string      name;
        logic [8:0] exp;
    } item_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [REG_W-1:0] dec_i_rs1, dec_i_rs2, exe_i_rd;
    logic             dec_i_use_rs1, dec_i_use_rs2, exe_i_is_load, exe_i_mispredict;
    logic             mem_i_req, mem_i_ready, wb_i_ebreak;
    logic             f_st, d_st, d_bub, e_st, e_bub, m_st, w_bub, halt, tmo;
    logic [31:0]      perf_stall, perf_flush, perf_lu;

    item_t sb[$];
    int    checks = 0;
    int    errors = 0;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .REG_W(REG_W)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .dec_i_rs1           (dec_i_rs1),
        .dec_i_rs2           (dec_i_rs2),
        .dec_i_use_rs1       (dec_i_use_rs1),
        .dec_i_use_rs2       (dec_i_use_rs2),
        .exe_i_rd            (exe_i_rd),
        .exe_i_is_load       (exe_i_is_load),
        .exe_i_mispredict    (exe_i_mispredict),
        .mem_i_req           (mem_i_req),
        .mem_i_ready         (mem_i_ready),
        .wb_i_ebreak         (wb_i_ebreak),
        .ctrl_o_regF_stall   (f_st),
        .ctrl_o_regD_stall   (d_st),
        .ctrl_o_regD_bubble  (d_bub),
        .ctrl_o_regE_stall   (e_st),
        .ctrl_o_regE_bubble  (e_bub),
        .ctrl_o_regM_stall   (m_st),
        .ctrl_o_regW_bubble  (w_bub),
        .ctrl_o_halt         (halt),
        .ctrl_o_timeout      (tmo),
        .perf_o_stall_cycles (perf_stall),
        .perf_o_flushes      (perf_flush),
        .perf_o_load_use     (perf_lu)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        item_t      it;
        logic [8:0] act;
        if (sb.size() > 0) begin
            it  = sb.pop_front();
            act = {f_st, d_st, d_bub, e_st, e_bub, m_st, w_bub, halt, tmo};
            checks++;
            if (act !== it.exp) begin
                errors++;
                $display("FAIL %s: got %b expected %b", it.name, act, it.exp);
            end
        end
    end

    task automatic idle();
        dec_i_rs1 = '0; dec_i_rs2 = '0; exe_i_rd = '0;
        dec_i_use_rs1 = 1'b0; dec_i_use_rs2 = 1'b0;
        exe_i_is_load = 1'b0; exe_i_mispredict = 1'b0;
        mem_i_req = 1'b0; mem_i_ready = 1'b0; wb_i_ebreak = 1'b0;
    endtask

    task automatic cyc(input string nm, input logic [8:0] e);
        item_t it;
        it.name = nm;
        it.exp  = e;
        sb.push_back(it);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic set_lu(input logic [REG_W-1:0] rd, input logic [REG_W-1:0] rs2);
        exe_i_is_load = 1'b1; exe_i_rd = rd;
        dec_i_rs2 = rs2; dec_i_use_rs2 = 1'b1;
    endtask

    task automatic direct(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    initial begin
        idle();
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        cyc("reset_idle", V_IDLE);

        set_lu(5'd5, 5'd5);            cyc("load_use_rs2", V_LU);
        idle();                        cyc("after_lu", V_IDLE);
        set_lu(5'd0, 5'd0);            cyc("load_use_rd0", V_IDLE);
        idle();
        exe_i_is_load = 1'b1; exe_i_rd = 5'd7; dec_i_rs1 = 5'd7; dec_i_use_rs1 = 1'b1;
        cyc("load_use_rs1", V_LU);
        dec_i_use_rs1 = 1'b0;          cyc("rs1_not_used", V_IDLE);
        exe_i_is_load = 1'b0; dec_i_use_rs1 = 1'b1;
        cyc("not_load", V_IDLE);
        idle(); set_lu(5'd9, 5'd9); exe_i_mispredict = 1'b1;
        cyc("misp_over_lu", V_MISP);

        idle(); mem_i_req = 1'b1;
        for (int i = 0; i < 3; i++) cyc("mem_wait", V_MEM);
        mem_i_ready = 1'b1;            cyc("mem_ready", V_IDLE);
        idle();                        cyc("mem_done_run", V_IDLE);
        exe_i_mispredict = 1'b1; mem_i_req = 1'b1;
        cyc("mem_wait_misp", V_MEM);
        cyc("mem_wait_misp", V_MEM);
        mem_i_ready = 1'b1;            cyc("misp_on_ready", V_MISP);
        idle(); mem_i_req = 1'b1;      cyc("drop_wait", V_MEM);
        mem_i_req = 1'b0;              cyc("req_dropped", V_IDLE);
        mem_i_req = 1'b1;
        for (int i = 0; i < 3; i++) cyc("post_drop_wait", V_MEM);
        mem_i_ready = 1'b1;            cyc("post_drop_ready", V_IDLE);

        do_reset(); mem_i_req = 1'b1;
        for (int i = 0; i < 4; i++) cyc("to_wait", V_MEM);
        for (int i = 0; i < 20; i++) begin
            mem_i_ready      = i[0];
            exe_i_mispredict = i[1];
            cyc("halt_timeout", V_HTO);
        end
        idle(); rst = 1'b1;            cyc("halt_in_rst", V_HTO);
        rst = 1'b0;                    cyc("rst_clears_halt", V_IDLE);

        wb_i_ebreak = 1'b1;            cyc("ebreak_run", V_IDLE);
        wb_i_ebreak = 1'b0;            cyc("ebreak_halt", V_HALT);
        cyc("ebreak_sticky", V_HALT);
        do_reset(); mem_i_req = 1'b1;  cyc("ebk_wait", V_MEM);
        wb_i_ebreak = 1'b1; mem_i_ready = 1'b1;
        cyc("ebk_ready", V_IDLE);
        idle();                        cyc("ebk_over_ready", V_HALT);

        do_reset(); mem_i_req = 1'b1;
        cyc("pre_rst_wait", V_MEM);
        cyc("pre_rst_wait", V_MEM);
        rst = 1'b1;                    cyc("rst_mid_wait", V_MEM);
        rst = 1'b0; idle();            cyc("after_rst_wait", V_IDLE);
        mem_i_req = 1'b1;
        for (int i = 0; i < 3; i++) cyc("cnt_cleared", V_MEM);
        mem_i_ready = 1'b1;            cyc("cnt_cleared_rdy", V_IDLE);

`ifdef PIPE_CTRL_PERF_EN
        do_reset();
        direct("perf_rst_lu", perf_lu, 32'd0);
        set_lu(5'd3, 5'd3);
        for (int i = 0; i < 3; i++) cyc("perf_lu_cyc", V_LU);
        idle(); exe_i_mispredict = 1'b1; cyc("perf_flush_cyc", V_MISP);
        idle();
        direct("perf_load_use", perf_lu, 32'd3);
        direct("perf_stall", perf_stall, 32'd3);
        direct("perf_flushes", perf_flush, 32'd1);
        wb_i_ebreak = 1'b1;            cyc("perf_ebreak", V_IDLE);
        idle(); set_lu(5'd3, 5'd3);    cyc("perf_halted", V_HALT);
        cyc("perf_halted", V_HALT);
        direct("perf_freeze", perf_lu, 32'd3);
`endif

        @(negedge clk); #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
